trap_arbiter: RTL
=================

Name: trap_arbiter

Overview:
- Parametrised successor to the core's interrupt/exception control logic in the CSR datapath.
- Synchronises NUM_IRQ external interrupt lines and holds per-source pending state, either level- or edge-triggered.
- Arbitrates exceptions against enabled interrupts and presents one registered trap request to the pipeline. The request is held stable until the pipeline acknowledges it.
- Produces the mcause value and the redirect PC. Vectoring is spec-correct: interrupts only.

Parameters:
- NUM_IRQ, 16: number of interrupt sources; legal range 1..32. Source i has cause code i.
- XLEN, 32: width of mtvec, trap_pc and trap_cause.
- SYNC_STAGES, 2: flop stages on each irq_in line; legal range 1..3.
- EDGE_MASK, 0 (NUM_IRQ bits): bit i = 1 makes source i edge-triggered; bit i = 0 makes it level-triggered.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines
- mie  in  NUM_IRQ  per-source enable
- MIE  in  1  global machine interrupt enable
- mtvec  in  XLEN  trap vector; bit 0 = vectored mode
- pc_reg_en  in  1  pipeline can accept a trap this cycle
- inst_addr_misaligned_mem, invalid_inst_mem, load_misaligned_mem, store_misaligned_mem, ecall_type  in  1 each  MEM-stage exception flags
- trap_ack  in  1  pipeline has redirected to trap_pc
- mret  in  1  retire of MRET
- irq_claim  in  1  clear the pending bit of an edge source
- claim_id  in  5  index of the source being cleared by irq_claim
- mip  out  NUM_IRQ  pending status
- trap_req  out  1  trap request
- trap_is_irq  out  1  1 = interrupt, 0 = exception
- trap_code  out  5  cause code
- trap_cause  out  XLEN  {trap_is_irq, zeros, trap_code}
- trap_pc  out  XLEN  redirect target
- in_trap  out  1  handler active; interrupts masked

Behaviour:
- Reset (asynchronous, any state): all synchroniser flops, mip, trap_req, trap_is_irq, trap_code, trap_cause, trap_pc and in_trap go to 0; FSM goes to IDLE.
- Synchroniser:
  - irq_in[i] passes through SYNC_STAGES flops to give s[i].
  - Level source: mip[i] is s[i] registered once more.
  - Edge source: a rising edge on s[i] sets mip[i]. irq_claim with claim_id == i clears it.
  - Set and claim in the same cycle: set wins. A claim_id >= NUM_IRQ or pointing at a level source is ignored.
- Selection (combinational, each cycle):
  - Exceptions have fixed priority and codes: inst_addr_misaligned = 0, invalid_inst = 2, load_misaligned = 4, store_misaligned = 6, ecall = 11.
  - Interrupt candidates are mip & mie, valid only when MIE = 1 and in_trap = 0. The lowest index wins.
  - An exception always beats an interrupt.
- FSM:
  - IDLE: if pc_reg_en and a candidate exists, latch is_irq, code, cause and pc, set trap_req = 1, go to REQ. First request is one cycle after the candidate appears.
  - REQ: trap_req and all latched outputs are frozen regardless of input changes, including the interrupt dropping. On trap_ack, clear trap_req, set in_trap = 1, go to HANDLER.
  - HANDLER: interrupts are masked. An exception with pc_reg_en latches a new request and goes to REQ; in_trap stays 1. mret clears in_trap and returns to IDLE. mret together with an exception: the exception wins.
  - mret in IDLE or REQ is ignored.
- Latency: level irq_in high to trap_req high = SYNC_STAGES + 2 cycles.
- Target PC:
  - base = {mtvec[XLEN-1:2], 2'b00}.
  - Interrupt with mtvec[0] = 1: trap_pc = base + (code << 2), XLEN-bit add, wraps modulo 2^XLEN.
  - Otherwise trap_pc = base, including all exceptions in vectored mode.
- trap_ack in IDLE is ignored.

Decomposition:
- Package trap_arbiter_pkg:
  - FSM state enum: IDLE, REQ, HANDLER.
  - CAUSE_W = 5.
  - Exception code localparams: EXC_IADDR_MIS = 0, EXC_ILLEGAL = 2, EXC_LD_MIS = 4, EXC_ST_MIS = 6, EXC_ECALL_M = 11.
- One sub-module, irq_source_cell: the synchroniser plus level/edge pending logic for a single source. It is instantiated NUM_IRQ times via generate, with parameters SYNC_STAGES and IS_EDGE.

Test Plan:
- Defaults; mtvec = 0x0000_1001, MIE = 1, mie[3] = 1, irq_in[3] held high, trap_ack held low -> trap_req rises 4 cycles later with code 3, trap_is_irq = 1, trap_cause = 0x8000_0003, trap_pc = 0x0000_100C.
- With irq 3 pending, assert invalid_inst_mem and pc_reg_en in the same cycle -> code 2, trap_is_irq = 0, trap_pc = 0x0000_1000 (exception, not vectored).
- In REQ, drop irq_in[3] and hold trap_ack low for 5 cycles -> all outputs unchanged. Then trap_ack -> trap_req = 0, in_trap = 1.
- EDGE_MASK bit 5 = 1; 1-cycle pulse on irq_in[5] -> mip[5] stays 1. irq_claim with claim_id = 5 in the cycle of a new edge -> mip[5] stays 1. A later claim alone -> mip[5] = 0.
- In HANDLER with irq 7 pending -> no request. mret -> IDLE, and on the next cycle trap_req is raised with code 7. Separately, mret with an ecall -> code 11, in_trap stays 1.
- Assert reset_n low mid-REQ -> all outputs 0 immediately, state IDLE. mtvec = 0xFFFF_FFFD with irq 3 -> trap_pc = 0x0000_0008 (wrap).

Source files
------------

// File: rtl/trap_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_arbiter_pkg
//  Description : Shared types and constants for the trap arbiter: FSM state
//                encoding, cause-code width and the fixed exception codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_arbiter_pkg;

    localparam int CAUSE_W = 5;

    // Synchronous exception cause codes (machine mode)
    localparam logic [CAUSE_W-1:0] EXC_IADDR_MIS = 5'd0;
    localparam logic [CAUSE_W-1:0] EXC_ILLEGAL   = 5'd2;
    localparam logic [CAUSE_W-1:0] EXC_LD_MIS    = 5'd4;
    localparam logic [CAUSE_W-1:0] EXC_ST_MIS    = 5'd6;
    localparam logic [CAUSE_W-1:0] EXC_ECALL_M   = 5'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/trap_arbiter_irq_source_cell.sv
`default_nettype none
// ============================================================================
//  Module      : irq_source_cell
//  Description : One interrupt source: SYNC_STAGES-deep synchroniser followed
//                by level or edge pending logic.
//  Ports       : clk, reset_n     - clock / async active-low reset
//                irq_i            - raw asynchronous interrupt line
//                claim_i          - clear request for an edge source
//                pend_o           - pending status (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_source_cell #(
    parameter int SYNC_STAGES = 2,
    parameter bit IS_EDGE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_i,
    input  logic claim_i,
    output logic pend_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= irq_i;
            end
        end else begin : g_syncn
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            end
        end
    endgenerate

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (IS_EDGE) begin : g_edge
            logic prev_q;
            logic pend_q;
            logic pend_d;

            // A new rising edge takes precedence over a simultaneous claim so
            // that an interrupt arriving during the claim is never lost.
            always_comb begin
                pend_d = pend_q;
                if (sync_s && !prev_q) pend_d = 1'b1;
                else if (claim_i)      pend_d = 1'b0;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_q <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    prev_q <= sync_s;
                    pend_q <= pend_d;
                end
            end

            assign pend_o = pend_q;
        end else begin : g_level
            logic pend_q;
            logic unused_claim;

            // Level sources cannot be claimed; the line itself is the status.
            assign unused_claim = claim_i;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) pend_q <= 1'b0;
                else          pend_q <= sync_s;
            end

            assign pend_o = pend_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/trap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : trap_arbiter
//  Description : Interrupt/exception arbiter for the CSR datapath. Holds
//                per-source pending state, selects between MEM-stage
//                exceptions and enabled interrupts, and presents one registered
//                trap request (cause + redirect PC) held until acknowledged.
//  Ports       : clk, reset_n            - clock / async active-low reset
//                irq_in, mie, MIE        - interrupt lines and enables
//                mtvec                   - trap vector (bit 0 = vectored)
//                pc_reg_en               - pipeline can take a trap
//                *_mem, ecall_type       - MEM-stage exception flags
//                trap_ack, mret          - handshake / handler exit
//                irq_claim, claim_id     - edge-source pending clear
//                mip                     - pending status
//                trap_req/is_irq/code/cause/pc - registered trap request
//                in_trap                 - handler active
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int                 NUM_IRQ     = 16,
    parameter int                 XLEN        = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  mie,
    input  logic                MIE,
    input  logic [XLEN-1:0]     mtvec,
    input  logic                pc_reg_en,
    input  logic                inst_addr_misaligned_mem,
    input  logic                invalid_inst_mem,
    input  logic                load_misaligned_mem,
    input  logic                store_misaligned_mem,
    input  logic                ecall_type,
    input  logic                trap_ack,
    input  logic                mret,
    input  logic                irq_claim,
    input  logic [4:0]          claim_id,
    output logic [NUM_IRQ-1:0]  mip,
    output logic                trap_req,
    output logic                trap_is_irq,
    output logic [CAUSE_W-1:0]  trap_code,
    output logic [XLEN-1:0]     trap_cause,
    output logic [XLEN-1:0]     trap_pc,
    output logic                in_trap
);

    // ------------------------------------------------------------------
    // Per-source synchroniser and pending state
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] pend_w;

    generate
        for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
            irq_source_cell #(
                .SYNC_STAGES (SYNC_STAGES),
                .IS_EDGE     (EDGE_MASK[g])
            ) u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .irq_i   (irq_in[g]),
                .claim_i (irq_claim && (claim_id == 5'(g))),
                .pend_o  (pend_w[g])
            );
        end
    endgenerate

    assign mip = pend_w;

    // ------------------------------------------------------------------
    // Candidate selection
    // ------------------------------------------------------------------
    state_e              state_q;
    logic                trap_req_q;
    logic                trap_is_irq_q;
    logic [CAUSE_W-1:0]  trap_code_q;
    logic [XLEN-1:0]     trap_cause_q;
    logic [XLEN-1:0]     trap_pc_q;
    logic                in_trap_q;

    logic                exc_valid_d;
    logic [CAUSE_W-1:0]  exc_code_d;
    logic [NUM_IRQ-1:0]  irq_cand_d;
    logic                irq_valid_d;
    logic [CAUSE_W-1:0]  irq_code_d;
    logic                sel_valid_d;
    logic                sel_is_irq_d;
    logic [CAUSE_W-1:0]  sel_code_d;
    logic [XLEN-1:0]     sel_cause_d;
    logic [XLEN-1:0]     base_d;
    logic [XLEN-1:0]     sel_pc_d;
    logic                unused_mtvec;

    always_comb begin
        exc_valid_d = 1'b1;
        exc_code_d  = EXC_IADDR_MIS;
        if      (inst_addr_misaligned_mem) exc_code_d = EXC_IADDR_MIS;
        else if (invalid_inst_mem)         exc_code_d = EXC_ILLEGAL;
        else if (load_misaligned_mem)      exc_code_d = EXC_LD_MIS;
        else if (store_misaligned_mem)     exc_code_d = EXC_ST_MIS;
        else if (ecall_type)               exc_code_d = EXC_ECALL_M;
        else                               exc_valid_d = 1'b0;
    end

    // Descending scan so the lowest-numbered pending source wins.
    always_comb begin
        irq_cand_d  = pend_w & mie;
        irq_valid_d = 1'b0;
        irq_code_d  = '0;
        if (MIE && !in_trap_q) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (irq_cand_d[i]) begin
                    irq_valid_d = 1'b1;
                    irq_code_d  = CAUSE_W'(i);
                end
            end
        end
    end

    assign sel_valid_d  = exc_valid_d || irq_valid_d;
    assign sel_is_irq_d = !exc_valid_d;
    assign sel_code_d   = exc_valid_d ? exc_code_d : irq_code_d;
    assign sel_cause_d  = {sel_is_irq_d, {(XLEN-1-CAUSE_W){1'b0}}, sel_code_d};

    // Only interrupts are vectored; exceptions always go to the base.
    assign base_d       = {mtvec[XLEN-1:2], 2'b00};
    assign sel_pc_d     = (sel_is_irq_d && mtvec[0])
                        ? base_d + {{(XLEN-CAUSE_W-2){1'b0}}, sel_code_d, 2'b00}
                        : base_d;
    assign unused_mtvec = mtvec[1];

    // ------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            trap_req_q    <= 1'b0;
            trap_is_irq_q <= 1'b0;
            trap_code_q   <= '0;
            trap_cause_q  <= '0;
            trap_pc_q     <= '0;
            in_trap_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_reg_en && sel_valid_d) begin
                        trap_req_q    <= 1'b1;
                        trap_is_irq_q <= sel_is_irq_d;
                        trap_code_q   <= sel_code_d;
                        trap_cause_q  <= sel_cause_d;
                        trap_pc_q     <= sel_pc_d;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (trap_ack) begin
                        trap_req_q <= 1'b0;
                        in_trap_q  <= 1'b1;
                        state_q    <= HANDLER;
                    end
                end
                HANDLER: begin
                    // in_trap masks interrupts here, so only exceptions
                    // can produce a nested request.
                    if (exc_valid_d && pc_reg_en) begin
                        trap_req_q    <= 1'b1;
                        trap_is_irq_q <= 1'b0;
                        trap_code_q   <= exc_code_d;
                        trap_cause_q  <= sel_cause_d;
                        trap_pc_q     <= sel_pc_d;
                        state_q       <= REQ;
                    end else if (mret) begin
                        in_trap_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trap_req    = trap_req_q;
    assign trap_is_irq = trap_is_irq_q;
    assign trap_code   = trap_code_q;
    assign trap_cause  = trap_cause_q;
    assign trap_pc     = trap_pc_q;
    assign in_trap     = in_trap_q;

endmodule
`default_nettype wire
